// File: rtl/lsu_issue_queue.sv
// lsu_issue_queue -- circular buffer of decoded LSU instructions between the
// clocked dispatch front end and the click-based LSU issue stage.
//
// Ports:
//   clk                    dispatch-domain clock, rising edge
//   rstn                   asynchronous active-low reset
//   i_DriveFromDispatch_1  dispatch offers an entry this cycle
//   i_Instruction_113      entry payload
//   o_FreeToDispatch_1     registered: queue accepts an entry this cycle
//   o_Entries_1808         flattened storage, entry k at [k*WIDTH +: WIDTH]
//   o_LSUCount_5           published gray write pointer
//   i_ReadPtrGray_5        gray read pointer from the issue stage (async domain)
//
// Optional feature (define LSU_QUEUE_OCC_EN):
//   o_Occupancy_5          registered wbin - gray2bin(synchronised read pointer)
//   o_AlmostFull_1         registered occupancy >= DEPTH-2
module lsu_issue_queue #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 113
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                i_DriveFromDispatch_1,
  input  logic [WIDTH-1:0]                    i_Instruction_113,
  output logic                                o_FreeToDispatch_1,
  output logic [(1<<DEPTH_LOG2)*WIDTH-1:0]    o_Entries_1808,
  output logic [DEPTH_LOG2:0]                 o_LSUCount_5,
  input  logic [DEPTH_LOG2:0]                 i_ReadPtrGray_5
`ifdef LSU_QUEUE_OCC_EN
  ,
  output logic [DEPTH_LOG2:0]                 o_Occupancy_5,
  output logic                                o_AlmostFull_1
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int          PW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wbin;
  logic [PW-1:0]    wgray;
  logic [PW-1:0]    wbinNext;
  logic [PW-1:0]    wgrayNext;
  logic [PW-1:0]    rsync1;
  logic [PW-1:0]    rgrayS;
  logic             doWrite;
  logic             full;

  assign doWrite   = i_DriveFromDispatch_1 & o_FreeToDispatch_1;
  assign wbinNext  = wbin + PW'(doWrite);
  assign wgray     = (wbin >> 1) ^ wbin;
  assign wgrayNext = (wbinNext >> 1) ^ wbinNext;

  // Full when the post-write pointer is exactly one lap ahead of the
  // synchronised read pointer: gray form flips the top two bits.
  assign full = (wgrayNext == {~rgrayS[PW-1:PW-2], rgrayS[PW-3:0]});

  // Plain two-flop synchroniser for the asynchronous read pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsync1 <= '0;
      rgrayS <= '0;
    end else begin
      rsync1 <= i_ReadPtrGray_5;
      rgrayS <= rsync1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wbin               <= '0;
      o_LSUCount_5       <= '0;
      o_FreeToDispatch_1 <= 1'b0;
    end else begin
      wbin               <= wbinNext;
      // Publishing the pre-edge pointer delays the count by one cycle so the
      // entry is stable a full period before the issue stage can see it.
      o_LSUCount_5       <= wgray;
      o_FreeToDispatch_1 <= ~full;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (doWrite) begin
      mem[wbin[DEPTH_LOG2-1:0]] <= i_Instruction_113;
    end
  end

  always_comb begin
    o_Entries_1808 = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      o_Entries_1808[k*WIDTH +: WIDTH] = mem[k];
    end
  end

`ifdef LSU_QUEUE_OCC_EN
  logic [PW-1:0] rbin;
  logic [PW-1:0] occ;

  // Gray to binary: bit i is the XOR of all gray bits at or above i.
  always_comb begin
    rbin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      rbin[i] = ^(rgrayS >> i);
    end
  end

  assign occ = wbin - rbin;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_Occupancy_5  <= '0;
      o_AlmostFull_1 <= 1'b0;
    end else begin
      o_Occupancy_5  <= occ;
      o_AlmostFull_1 <= (occ >= PW'(DEPTH - 2));
    end
  end
`endif

endmodule

// File: tb/tb_lsu_issue_queue.sv
module tb_lsu_issue_queue;

  localparam int W = 113;
  localparam int D = 16;

  logic           clk = 1'b0;
  logic           rstn = 1'b1;
  logic           drive = 1'b0;
  logic [W-1:0]   instr = '0;
  logic           free;
  logic [D*W-1:0] entries;
  logic [4:0]     count;
  logic [4:0]     rdGray = '0;
`ifdef LSU_QUEUE_OCC_EN
  logic [4:0]     occ;
  logic           almostFull;
`endif

  lsu_issue_queue #(.DEPTH_LOG2(4), .WIDTH(W)) dut (
    .clk                   (clk),
    .rstn                  (rstn),
    .i_DriveFromDispatch_1 (drive),
    .i_Instruction_113     (instr),
    .o_FreeToDispatch_1    (free),
    .o_Entries_1808        (entries),
    .o_LSUCount_5          (count),
    .i_ReadPtrGray_5       (rdGray)
`ifdef LSU_QUEUE_OCC_EN
    ,
    .o_Occupancy_5         (occ),
    .o_AlmostFull_1        (almostFull)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: total writes modulo 32, read-pointer history as seen
  // through two cycles of synchroniser delay, and a plain entry array.
  int         mw;
  int         rdBin;
  logic       mFree;
  logic [4:0] mCount;
  int         mOcc;
  logic [W-1:0] mMem [D];
  int         hist[$];

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mw = 0; mFree = 1'b0; mCount = '0; mOcc = 0;
    for (int k = 0; k < D; k++) mMem[k] = '0;
    hist = '{0, 0};
  endtask

  task automatic checkAll(input string ph);
    chk({ph, ".free"}, 128'(free), 128'(mFree));
    chk({ph, ".count"}, 128'(count), 128'(mCount));
    for (int k = 0; k < D; k++)
      chk($sformatf("%s.entry%0d", ph, k), 128'(entries[k*W +: W]), 128'(mMem[k]));
`ifdef LSU_QUEUE_OCC_EN
    chk({ph, ".occ"}, 128'(occ), 128'(mOcc));
    chk({ph, ".almostFull"}, 128'(almostFull), 128'(mOcc >= D - 2));
`endif
  endtask

  // One clock edge: predict from the pre-edge state, then compare at edge+1.
  task automatic step(input string ph);
    int used;
    int wAfter;
    logic wr;
    rdGray = gray5(rdBin);
    used   = hist[0];
    wr     = drive && mFree;
    wAfter = (mw + (wr ? 1 : 0)) & 31;
    @(posedge clk);
    #1;
    if (wr) mMem[mw % D] = instr;
    mCount = gray5(mw);
    mOcc   = (mw - used) & 31;
    mFree  = (((wAfter - used) & 31) != D);
    mw     = wAfter;
    void'(hist.pop_front());
    hist.push_back(rdBin);
    checkAll(ph);
  endtask

  task automatic asyncReset(input string ph);
    #2 rstn = 1'b0;
    #1;
    modelReset();
    chk({ph, ".count0"}, 128'(count), 128'(0));
    chk({ph, ".free0"}, 128'(free), 128'(0));
    chk({ph, ".entries0"}, 128'(entries == '0), 128'(1));
    #1 rstn = 1'b1;
    drive = 1'b0;
  endtask

  function automatic logic [W-1:0] rndPayload();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [W-1:0] p0;
    logic [W-1:0] px;
    logic [4:0]   prevCount;

    rdBin = 0;
    modelReset();
    #2 rstn = 1'b0;
    #1;
    chk("reset.free", 128'(free), 128'(0));
    chk("reset.count", 128'(count), 128'(0));
    chk("reset.entries", 128'(entries == '0), 128'(1));
    #4 rstn = 1'b1;
    step("release");
    chk("release.freeUp", 128'(free), 128'(1));

    // Single write of 113'h1_2345.
    drive = 1'b1; instr = 113'h1_2345;
    step("single1");
    chk("single.entry0", 128'(entries[0 +: W]), 128'h1_2345);
    drive = 1'b0;
    step("single2");
    chk("single.count", 128'(count), 128'(5'b00001));

    // Four more writes, then reset in the middle of a write cycle.
    drive = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr = rndPayload();
      step("pre5");
    end
    asyncReset("midReset");
    step("midRelease");
    chk("midRelease.freeUp", 128'(free), 128'(1));

    // Fill with the read pointer held at 0.
    rdBin = 0;
    drive = 1'b1;
    for (int i = 0; i < 16; i++) begin
      instr = rndPayload();
      if (i == 0) p0 = instr;
      step("fill");
    end
    chk("fill.freeLow", 128'(free), 128'(0));
    instr = rndPayload();
    step("fill17");
    chk("fill17.entry0", 128'(entries[0 +: W]), 128'(p0));
    chk("fill17.count", 128'(count), 128'(5'b11000));
    drive = 1'b0;

    // Drain one: free reappears exactly three edges later.
    rdBin = 1;
    step("drain1");
    chk("drain.e1", 128'(free), 128'(0));
    step("drain2");
    chk("drain.e2", 128'(free), 128'(0));
    step("drain3");
    chk("drain.e3", 128'(free), 128'(1));
    drive = 1'b1; px = rndPayload(); instr = px;
    step("drainW");
    chk("drainW.entry0", 128'(entries[0 +: W]), 128'(px));
    drive = 1'b0;
    step("drainC");
    chk("drainC.count17", 128'(count), 128'(5'b11001));

    // Wrap-around: 40 writes with the read pointer lagging by 2.
    rdBin = 15;
    for (int i = 0; i < 3; i++) step("wrapPrep");
    drive = 1'b1;
    for (int i = 0; i < 40; i++) begin
      prevCount = count;
      rdBin = (mw - 2) & 31;
      instr = rndPayload();
      step("wrap");
      chk("wrap.noStall", 128'(free), 128'(1));
      if (i >= 1) chk("wrap.oneBit", 128'($countones(count ^ prevCount)), 128'(1));
    end
    drive = 1'b0;

    // Occupancy / almost-full.
    asyncReset("occReset");
    rdBin = 0;
    step("occRelease");
    drive = 1'b1;
    for (int i = 0; i < 14; i++) begin
      instr = rndPayload();
      step("occFill");
    end
    drive = 1'b0;
    step("occAfter");
`ifdef LSU_QUEUE_OCC_EN
    chk("occ.14", 128'(occ), 128'(14));
    chk("occ.af1", 128'(almostFull), 128'(1));
`endif
    rdBin = 3;
    for (int i = 0; i < 3; i++) step("occRd");
`ifdef LSU_QUEUE_OCC_EN
    chk("occ.11", 128'(occ), 128'(11));
    chk("occ.af0", 128'(almostFull), 128'(0));
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive = ($urandom % 4) != 0;
      instr = rndPayload();
      if ((((mw - rdBin) & 31) != 0) && ($urandom % 3 == 0))
        rdBin = (rdBin + 1) & 31;
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
